// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep sequencer for a DDS core. On a start pulse it latches a
// sweep configuration and then walks the frequency word from f_start towards
// f_stop in f_step increments. Each frequency is held for `dwell` cycles.
// The last word is always exactly f_stop: an overshooting step is clamped,
// never wrapped. In single mode the sweep ends with a one-cycle done pulse.
// In repeat mode it restarts from f_start until stopped.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   one-cycle pulse, begins a sweep (accepted only when idle)
//   stop       in   one-cycle pulse, aborts a sweep; wins over start
//   mode       in   0 = single sweep, 1 = repeat
//   f_start    in   first frequency word
//   f_stop     in   final frequency word (upper bound)
//   f_step     in   increment per step
//   dwell      in   cycles each frequency is held (0 behaves as 1)
//   phase_in   in   phase offset, latched on start
//   Freword    out  registered frequency word to the DDS core
//   Phaword    out  registered phase word to the DDS core
//   busy       out  high while a sweep is active
//   step_tick  out  one-cycle pulse after every sweep-driven Freword update
//   done       out  one-cycle pulse at the end of a single sweep
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FrequencyBitWidth = 32,
    parameter int PhaseBitWidth     = 10,
    parameter int DwellBitWidth     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         mode,
    input  logic [FrequencyBitWidth-1:0] f_start,
    input  logic [FrequencyBitWidth-1:0] f_stop,
    input  logic [FrequencyBitWidth-1:0] f_step,
    input  logic [DwellBitWidth-1:0]     dwell,
    input  logic [PhaseBitWidth-1:0]     phase_in,
    output logic [FrequencyBitWidth-1:0] Freword,
    output logic [PhaseBitWidth-1:0]     Phaword,
    output logic                         busy,
    output logic                         step_tick,
    output logic                         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [FrequencyBitWidth-1:0] FREQ_ZERO  = {FrequencyBitWidth{1'b0}};
    localparam logic [PhaseBitWidth-1:0]     PHASE_ZERO = {PhaseBitWidth{1'b0}};
    localparam logic [DwellBitWidth-1:0]     DWELL_ZERO = {DwellBitWidth{1'b0}};
    localparam logic [DwellBitWidth-1:0]     DWELL_ONE  = {{(DwellBitWidth-1){1'b0}}, 1'b1};

    // Registered state, outputs and latched configuration
    state_t                         r_state;
    logic [FrequencyBitWidth-1:0]   r_freword;
    logic [PhaseBitWidth-1:0]       r_phaword;
    logic                           r_busy;
    logic                           r_step_tick;
    logic                           r_done;
    logic [DwellBitWidth-1:0]       r_dwell_cnt;
    logic                           r_final;
    logic [FrequencyBitWidth-1:0]   r_f_start;
    logic [FrequencyBitWidth-1:0]   r_f_stop;
    logic [FrequencyBitWidth-1:0]   r_f_step;
    logic [DwellBitWidth-1:0]       r_dwell_m1;
    logic                           r_mode;

    // Next-state values produced by the combinational process
    state_t                         w_state_nxt;
    logic [FrequencyBitWidth-1:0]   w_freword_nxt;
    logic [PhaseBitWidth-1:0]       w_phaword_nxt;
    logic                           w_busy_nxt;
    logic                           w_step_tick_nxt;
    logic                           w_done_nxt;
    logic [DwellBitWidth-1:0]       w_dwell_cnt_nxt;
    logic                           w_final_nxt;
    logic [FrequencyBitWidth-1:0]   w_f_start_nxt;
    logic [FrequencyBitWidth-1:0]   w_f_stop_nxt;
    logic [FrequencyBitWidth-1:0]   w_f_step_nxt;
    logic [DwellBitWidth-1:0]       w_dwell_m1_nxt;
    logic                           w_mode_nxt;

    // Helpers
    logic [FrequencyBitWidth:0]     w_sum;
    logic [DwellBitWidth-1:0]       w_dwell_in_m1;

    // One extra bit so a carry-out counts as "at or beyond f_stop" instead of wrapping
    assign w_sum = {1'b0, r_freword} + {1'b0, r_f_step};

    // Reload value for the dwell counter; a zero dwell behaves like one cycle
    assign w_dwell_in_m1 = (dwell == DWELL_ZERO) ? DWELL_ZERO : (dwell - DWELL_ONE);

    // Next-state and next-output logic for the sweep FSM
    always_comb begin
        w_state_nxt     = r_state;
        w_freword_nxt   = r_freword;
        w_phaword_nxt   = r_phaword;
        w_busy_nxt      = r_busy;
        w_step_tick_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_final_nxt     = r_final;
        w_f_start_nxt   = r_f_start;
        w_f_stop_nxt    = r_f_stop;
        w_f_step_nxt    = r_f_step;
        w_dwell_m1_nxt  = r_dwell_m1;
        w_mode_nxt      = r_mode;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_f_start_nxt   = f_start;
                    w_f_stop_nxt    = f_stop;
                    w_f_step_nxt    = f_step;
                    w_dwell_m1_nxt  = w_dwell_in_m1;
                    w_mode_nxt      = mode;
                    w_freword_nxt   = f_start;
                    w_phaword_nxt   = phase_in;
                    w_busy_nxt      = 1'b1;
                    w_step_tick_nxt = 1'b1;
                    w_dwell_cnt_nxt = w_dwell_in_m1;
                    // A start at or past the bound is already the last word
                    w_final_nxt     = (f_start >= f_stop);
                    w_state_nxt     = ST_DWELL;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end

            ST_DWELL: begin
                if (stop) begin
                    // Abort: words freeze where they are, no done pulse
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_dwell_cnt != DWELL_ZERO) begin
                    w_dwell_cnt_nxt = r_dwell_cnt - DWELL_ONE;
                end else if (r_f_step == FREQ_ZERO) begin
                    // Zero step parks on f_start until stop or reset
                    w_dwell_cnt_nxt = DWELL_ZERO;
                end else begin
                    w_dwell_cnt_nxt = r_dwell_m1;
                    if (!r_final) begin
                        if (w_sum < {1'b0, r_f_stop}) begin
                            w_freword_nxt = w_sum[FrequencyBitWidth-1:0];
                        end else begin
                            w_freword_nxt = r_f_stop;
                            w_final_nxt   = 1'b1;
                        end
                        w_step_tick_nxt = 1'b1;
                    end else if (r_mode) begin
                        w_freword_nxt   = r_f_start;
                        w_final_nxt     = (r_f_start >= r_f_stop);
                        w_step_tick_nxt = 1'b1;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, output and configuration registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_freword   <= FREQ_ZERO;
            r_phaword   <= PHASE_ZERO;
            r_busy      <= 1'b0;
            r_step_tick <= 1'b0;
            r_done      <= 1'b0;
            r_dwell_cnt <= DWELL_ZERO;
            r_final     <= 1'b0;
            r_f_start   <= FREQ_ZERO;
            r_f_stop    <= FREQ_ZERO;
            r_f_step    <= FREQ_ZERO;
            r_dwell_m1  <= DWELL_ZERO;
            r_mode      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_freword   <= w_freword_nxt;
            r_phaword   <= w_phaword_nxt;
            r_busy      <= w_busy_nxt;
            r_step_tick <= w_step_tick_nxt;
            r_done      <= w_done_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_final     <= w_final_nxt;
            r_f_start   <= w_f_start_nxt;
            r_f_stop    <= w_f_stop_nxt;
            r_f_step    <= w_f_step_nxt;
            r_dwell_m1  <= w_dwell_m1_nxt;
            r_mode      <= w_mode_nxt;
        end
    end

    assign Freword   = r_freword;
    assign Phaword   = r_phaword;
    assign busy      = r_busy;
    assign step_tick = r_step_tick;
    assign done      = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Directed bench for dds_sweep_ctrl: single sweep, clamp at the top of the
// word range, repeat mode with stop, zero step / zero dwell, reset mid-sweep.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so each check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [9:0]  phase_in;
    logic [31:0] Freword;
    logic [9:0]  Phaword;
    logic        busy;
    logic        step_tick;
    logic        done;

    int n_vec;
    int n_err;
    int ticks;

    dds_sweep_ctrl #(
        .FrequencyBitWidth (32),
        .PhaseBitWidth     (10),
        .DwellBitWidth     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phase_in  (phase_in),
        .Freword   (Freword),
        .Phaword   (Phaword),
        .busy      (busy),
        .step_tick (step_tick),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start with a configuration, then scramble the config inputs so
    // any later sampling of them would show up as a wrong word.
    task automatic go(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] fp,
                      input logic [15:0] dw, input logic m, input logic [9:0] ph);
        f_start  = fs;
        f_stop   = fe;
        f_step   = fp;
        dwell    = dw;
        mode     = m;
        phase_in = ph;
        start    = 1'b1;
        step();
        start    = 1'b0;
        f_start  = 32'h0BAD_0BAD;
        f_stop   = 32'h0000_0001;
        f_step   = 32'h0000_0003;
        dwell    = 16'd7;
        mode     = ~m;
        phase_in = 10'h3FF;
    endtask

    initial begin
        logic [31:0] exp1 [4];
        logic [31:0] e3;

        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        f_start  = 32'd0;
        f_stop   = 32'd0;
        f_step   = 32'd0;
        dwell    = 16'd0;
        phase_in = 10'd0;
        exp1[0] = 32'd100;
        exp1[1] = 32'd150;
        exp1[2] = 32'd200;
        exp1[3] = 32'd250;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_freword", Freword, 32'd0);
        chk("rst_phaword", Phaword, 10'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tick", step_tick, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        step();

        // ---------------- single sweep 100..250 step 50 dwell 3 ----------------
        go(32'd100, 32'd250, 32'd50, 16'd3, 1'b0, 10'h011);
        chk("t1_phaword", Phaword, 10'h011);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            chk("t1_freq", Freword, exp1[i / 3]);
            chk("t1_tick", step_tick, ((i % 3) == 0) ? 1'b1 : 1'b0);
            chk("t1_busy", busy, 1'b1);
            chk("t1_done", done, 1'b0);
            if (step_tick) ticks++;
            step();
        end
        chk("t1_tick_count", ticks, 4);
        chk("t1_done_pulse", done, 1'b1);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_freq_end", Freword, 32'd250);
        step();
        chk("t1_done_clear", done, 1'b0);
        chk("t1_freq_hold", Freword, 32'd250);
        chk("t1_idle_busy", busy, 1'b0);

        // ---------------- clamp at top of range, dwell 1 ----------------
        go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 1'b0, 10'h022);
        chk("t2_first", Freword, 32'hFFFF_FFF0);
        chk("t2_tick0", step_tick, 1'b1);
        step();
        chk("t2_clamp", Freword, 32'hFFFF_FFFF);
        chk("t2_tick1", step_tick, 1'b1);
        chk("t2_busy", busy, 1'b1);
        chk("t2_nodone", done, 1'b0);
        step();
        chk("t2_done", done, 1'b1);
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_freq_end", Freword, 32'hFFFF_FFFF);
        chk("t2_tick_end", step_tick, 1'b0);
        step();
        chk("t2_done_clear", done, 1'b0);

        // ---------------- repeat 10,20,30 dwell 2, then stop ----------------
        go(32'd10, 32'd30, 32'd10, 16'd2, 1'b1, 10'h033);
        for (int i = 0; i < 13; i++) begin
            e3 = 32'd10 * (32'((i / 2) % 3) + 32'd1);
            chk("t3_freq", Freword, e3);
            chk("t3_tick", step_tick, ((i % 2) == 0) ? 1'b1 : 1'b0);
            chk("t3_busy", busy, 1'b1);
            chk("t3_nodone", done, 1'b0);
            step();
        end
        chk("t3_mid_dwell", Freword, 32'd10);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t3_stop_busy", busy, 1'b0);
        chk("t3_stop_freq", Freword, 32'd10);
        chk("t3_stop_nodone", done, 1'b0);
        chk("t3_stop_phase", Phaword, 10'h033);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_frozen", Freword, 32'd10);
            chk("t3_idle_tick", step_tick, 1'b0);
            chk("t3_idle_done", done, 1'b0);
        end

        // ---------------- zero step, zero dwell ----------------
        go(32'd77, 32'd500, 32'd0, 16'd0, 1'b0, 10'h03A);
        chk("t4_load", Freword, 32'd77);
        chk("t4_tick0", step_tick, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_hold", Freword, 32'd77);
            chk("t4_notick", step_tick, 1'b0);
            chk("t4_busy", busy, 1'b1);
            chk("t4_nodone", done, 1'b0);
        end
        go(32'd5, 32'd9, 32'd1, 16'd1, 1'b0, 10'h111);
        chk("t4_restart_ignored", Freword, 32'd77);
        chk("t4_restart_phase", Phaword, 10'h03A);
        chk("t4_restart_notick", step_tick, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_stop_busy", busy, 1'b0);
        chk("t4_stop_freq", Freword, 32'd77);
        // start and stop together while idle: nothing happens
        f_start  = 32'd999;
        f_stop   = 32'd2000;
        f_step   = 32'd1;
        dwell    = 16'd1;
        phase_in = 10'h0F0;
        start    = 1'b1;
        stop     = 1'b1;
        step();
        start    = 1'b0;
        stop     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_ss_busy", busy, 1'b0);
            chk("t4_ss_freq", Freword, 32'd77);
            chk("t4_ss_phase", Phaword, 10'h03A);
            chk("t4_ss_tick", step_tick, 1'b0);
            step();
        end

        // ---------------- reset mid-sweep, then a fresh sweep ----------------
        go(32'd1000, 32'd1003, 32'd1, 16'd4, 1'b0, 10'h155);
        chk("t5_phase", Phaword, 10'h155);
        for (int i = 0; i < 5; i++) step();
        chk("t5_pre_rst", Freword, 32'd1001);
        rst   = 1'b1;
        start = 1'b1;
        step();
        chk("t5_rst_freq", Freword, 32'd0);
        chk("t5_rst_phase", Phaword, 10'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_tick", step_tick, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        step();
        chk("t5_rst_start_ignored", busy, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_post_done", done, 1'b0);
            chk("t5_post_busy", busy, 1'b0);
        end
        go(32'd20, 32'd30, 32'd5, 16'd1, 1'b0, 10'h2AA);
        chk("t5_new_phase", Phaword, 10'h2AA);
        chk("t5_new_f0", Freword, 32'd20);
        step();
        chk("t5_new_f1", Freword, 32'd25);
        step();
        chk("t5_new_f2", Freword, 32'd30);
        chk("t5_new_tick2", step_tick, 1'b1);
        step();
        chk("t5_new_done", done, 1'b1);
        chk("t5_new_busy", busy, 1'b0);
        chk("t5_new_freq_end", Freword, 32'd30);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
